// File: rtl/spi_slave_io_if.sv
// Pin, configuration and byte-stream signals of the SPI slave.
// The slave modport is the core's view; the master modport is the host/pad side.
interface spi_slave_io_if;
    logic       cpol;
    logic       cpha;
    logic       lsbfirst;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_load;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_access;
    logic [1:0] spi_state;

    modport slave (
        input  cpol, cpha, lsbfirst, sclk, ss, mosi, tx_data, tx_empty,
        output miso, miso_oe, tx_load, tx_underrun, rx_data, rx_valid, rx_access, spi_state
    );

    modport master (
        output cpol, cpha, lsbfirst, sclk, ss, mosi, tx_data, tx_empty,
        input  miso, miso_oe, tx_load, tx_underrun, rx_data, rx_valid, rx_access, spi_state
    );
endinterface

// File: rtl/spi_slave_io.sv
// SPI slave, all four modes, oversampled in the clk domain.
// Sync chains on sclk/ss/mosi; 2-cycle LOAD fetches the first byte before data edges count.
module spi_slave_io #(
    parameter int SYNC = 2
) (
    input  logic            clk,
    input  logic            nreset,
    spi_slave_io_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, DATA = 2'b10} state_t;

    state_t          r_state;
    logic [SYNC-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic            r_sclk_d, r_ss_d;
    logic            r_load_cnt;
    logic            r_fetch, r_fetch_ur;
    logic [7:0]      r_hold, r_tx_sr, r_rx_sr, r_rx_data;
    logic [2:0]      r_bit_cnt;
    logic            r_reload;
    logic            r_tx_load, r_tx_underrun, r_rx_valid, r_rx_access;

    logic       w_sclk, w_ss, w_mosi;
    logic       w_rise, w_fall, w_sample, w_shift, w_ss_fall, w_ss_rise;
    logic [7:0] w_rx_next, w_fetch_byte;

    assign w_sclk    = r_sclk_sync[SYNC-1];
    assign w_ss      = r_ss_sync[SYNC-1];
    assign w_mosi    = r_mosi_sync[SYNC-1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    // Modes 0 and 3 sample on rising sclk, modes 1 and 2 on falling.
    assign w_sample  = (bus.cpol ^ bus.cpha) ? w_fall : w_rise;
    assign w_shift   = (bus.cpol ^ bus.cpha) ? w_rise : w_fall;
    assign w_ss_fall = r_ss_d & ~w_ss;
    assign w_ss_rise = ~r_ss_d & w_ss;
    assign w_rx_next = bus.lsbfirst ? {w_mosi, r_rx_sr[7:1]} : {r_rx_sr[6:0], w_mosi};
    assign w_fetch_byte = r_fetch_ur ? 8'h00 : bus.tx_data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= IDLE;
            r_sclk_sync   <= '0;
            r_ss_sync     <= '1;
            r_mosi_sync   <= '0;
            r_sclk_d      <= 1'b0;
            r_ss_d        <= 1'b1;
            r_load_cnt    <= 1'b0;
            r_fetch       <= 1'b0;
            r_fetch_ur    <= 1'b0;
            r_hold        <= 8'h00;
            r_tx_sr       <= 8'h00;
            r_rx_sr       <= 8'h00;
            r_rx_data     <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_reload      <= 1'b0;
            r_tx_load     <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_rx_access   <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC-2:0], bus.sclk};
            r_ss_sync     <= {r_ss_sync[SYNC-2:0], bus.ss};
            r_mosi_sync   <= {r_mosi_sync[SYNC-2:0], bus.mosi};
            r_sclk_d      <= w_sclk;
            r_ss_d        <= w_ss;
            r_tx_load     <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_rx_access   <= w_ss_rise;
            // tx_data is valid the cycle after a request; capture it then.
            r_fetch       <= r_tx_load | r_tx_underrun;
            r_fetch_ur    <= r_tx_underrun;
            if (r_fetch)
                r_hold <= w_fetch_byte;

            if (w_ss) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (w_ss_fall) begin
                        r_state       <= LOAD;
                        r_load_cnt    <= 1'b0;
                        r_bit_cnt     <= 3'd0;
                        r_reload      <= bus.cpha;
                        r_tx_load     <= ~bus.tx_empty;
                        r_tx_underrun <= bus.tx_empty;
                    end
                    LOAD: begin
                        r_load_cnt <= 1'b1;
                        if (r_load_cnt) begin
                            r_state <= DATA;
                            r_tx_sr <= w_fetch_byte;
                        end
                    end
                    DATA: if (w_sample) begin
                        r_rx_sr   <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data     <= w_rx_next;
                            r_rx_valid    <= 1'b1;
                            r_reload      <= 1'b1;
                            r_tx_load     <= ~bus.tx_empty;
                            r_tx_underrun <= bus.tx_empty;
                        end
                    end else if (w_shift) begin
                        if (r_reload) begin
                            r_tx_sr  <= r_hold;
                            r_reload <= 1'b0;
                        end else begin
                            r_tx_sr <= bus.lsbfirst ? {1'b0, r_tx_sr[7:1]} : {r_tx_sr[6:0], 1'b0};
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.miso        = ~w_ss & (bus.lsbfirst ? r_tx_sr[0] : r_tx_sr[7]);
    assign bus.miso_oe     = ~w_ss;
    assign bus.tx_load     = r_tx_load;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_access   = r_rx_access;
    assign bus.spi_state   = r_state;
endmodule

// File: tb/tb_spi_slave_io.sv
// Directed bench for spi_slave_io: a bit-level SPI master drives frames, a byte-level
// model predicts received bytes, miso bytes and pulse counts.
module tb_spi_slave_io;
    localparam int TB_SYNC = 3;
    localparam int H       = TB_SYNC + 3;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    spi_slave_io_if bus ();

    spi_slave_io #(.SYNC(TB_SYNC)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_src[$];
    int n_load = 0, n_ur = 0, n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host side: answer each tx_load with the next queued byte.
    always @(negedge clk) begin
        if (nreset && bus.tx_load) begin
            if (tx_src.size() > 0) bus.tx_data = tx_src.pop_front();
            else                   bus.tx_data = 8'hEE;
        end
    end

    // Per-cycle comparison against the byte-level model.
    always @(negedge clk) begin
        if (nreset) begin
            if (bus.tx_load)     n_load++;
            if (bus.tx_underrun) n_ur++;
            if (bus.rx_access)   n_acc++;
            if (bus.rx_valid) begin
                if (rx_exp.size() == 0) chk("rx_valid_unexpected", bus.rx_valid, 1'b0);
                else                    chk("rx_data", bus.rx_data, rx_exp.pop_front());
            end
            if (!bus.miso_oe) chk("miso_when_deselected", bus.miso, 1'b0);
            chk("load_and_underrun", bus.tx_load & bus.tx_underrun, 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_h();
        repeat (H) @(posedge clk);
        #3;
    endtask

    task automatic set_mode(input bit p, input bit a, input bit l);
        bus.cpol     = p;
        bus.cpha     = a;
        bus.lsbfirst = l;
        bus.sclk     = p;
        repeat (10) @(posedge clk);
        #3;
    endtask

    task automatic xfer_bit(input bit mo, output bit mi);
        if (!bus.cpha) begin
            bus.mosi = mo;
            wait_h();
            mi = bus.miso;
            bus.sclk = ~bus.cpol;
            wait_h();
            bus.sclk = bus.cpol;
        end else begin
            bus.sclk = ~bus.cpol;
            bus.mosi = mo;
            wait_h();
            mi = bus.miso;
            bus.sclk = bus.cpol;
            wait_h();
        end
    endtask

    task automatic start_frame();
        bus.ss = 1'b0;
        repeat (TB_SYNC + 6) @(posedge clk);
        #3;
    endtask

    task automatic end_frame();
        if (!bus.cpha) wait_h();
        bus.ss = 1'b1;
        repeat (TB_SYNC + 6) @(posedge clk);
        #3;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] mo[$], input logic [7:0] to[$],
                             input int nbits);
        int l0, u0, a0, nfull, pos;
        logic [7:0] rb, em;
        bit mi;
        l0 = n_load; u0 = n_ur; a0 = n_acc;
        nfull = nbits / 8;
        tx_src = to;
        for (int j = 0; j < nfull; j++) rx_exp.push_back(mo[j]);
        start_frame();
        rb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            pos = bus.lsbfirst ? (i % 8) : 7 - (i % 8);
            xfer_bit(mo[i/8][pos], mi);
            rb[pos] = mi;
            if (i % 8 == 7) begin
                em = (bus.tx_empty || (i/8) >= to.size()) ? 8'h00 : to[i/8];
                chk({tag, " miso_byte"}, rb, em);
                rb = 8'h00;
            end
        end
        end_frame();
        chk({tag, " rx_valid_count"}, rx_exp.size(), 0);
        rx_exp.delete();
        chk({tag, " rx_access_count"}, n_acc - a0, 1);
        if (bus.tx_empty) begin
            chk({tag, " underrun_count"}, n_ur - u0, nfull + 1);
            chk({tag, " tx_load_count"}, n_load - l0, 0);
        end else begin
            chk({tag, " tx_load_count"}, n_load - l0, nfull + 1);
            chk({tag, " underrun_count"}, n_ur - u0, 0);
        end
        chk({tag, " state_idle"}, bus.spi_state, 2'b00);
    endtask

    initial begin
        logic [7:0] qm[$];
        logic [7:0] qt[$];
        int l0, a0, u0;
        bit mi;
        bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfirst = 1'b0;
        bus.tx_data = 8'h00; bus.tx_empty = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("reset spi_state", bus.spi_state, 2'b00);
        chk("reset miso", bus.miso, 1'b0);
        chk("reset miso_oe", bus.miso_oe, 1'b0);
        chk("reset tx_load", bus.tx_load, 1'b0);
        chk("reset tx_underrun", bus.tx_underrun, 1'b0);
        chk("reset rx_valid", bus.rx_valid, 1'b0);
        chk("reset rx_access", bus.rx_access, 1'b0);
        chk("reset rx_data", bus.rx_data, 8'h00);
        nreset = 1'b1;
        repeat (5) @(posedge clk);
        #3;

        // Mode 0, MSB first, single byte.
        set_mode(1'b0, 1'b0, 1'b0);
        qm.delete(); qt.delete(); qm.push_back(8'hA5); qt.push_back(8'h3C);
        run_frame("mode0", qm, qt, 8);
        chk("mode0 rx_data literal", bus.rx_data, 8'hA5);

        // Mode 3, LSB first, two bytes.
        set_mode(1'b1, 1'b1, 1'b1);
        qm.delete(); qt.delete();
        qm.push_back(8'h01); qm.push_back(8'h80);
        qt.push_back(8'h12); qt.push_back(8'h34);
        l0 = n_load;
        run_frame("mode3", qm, qt, 16);
        chk("mode3 rx_data literal", bus.rx_data, 8'h80);
        chk("mode3 tx_load literal", n_load - l0, 3);

        // Mode 1 with no transmit data available.
        set_mode(1'b0, 1'b1, 1'b0);
        bus.tx_empty = 1'b1;
        qm.delete(); qt.delete();
        qm.push_back(8'hC3); qm.push_back(8'h7E);
        u0 = n_ur;
        run_frame("mode1_empty", qm, qt, 16);
        chk("mode1 underrun literal", n_ur - u0, 3);
        chk("mode1 rx_data literal", bus.rx_data, 8'h7E);
        bus.tx_empty = 1'b0;

        // Frame aborted after 5 bits: rx_data keeps the previous byte.
        set_mode(1'b0, 1'b0, 1'b0);
        qm.delete(); qt.delete(); qm.push_back(8'hFF); qt.push_back(8'h81);
        run_frame("partial5", qm, qt, 5);
        chk("partial5 rx_data unchanged", bus.rx_data, 8'h7E);

        // Zero-bit frame still produces one rx_access.
        qm.delete(); qt.delete(); qt.push_back(8'h42);
        run_frame("zero_bits", qm, qt, 0);

        // Reset asserted after bit 3 of a frame.
        tx_src.delete(); tx_src.push_back(8'h99);
        start_frame();
        xfer_bit(1'b0, mi);
        xfer_bit(1'b1, mi);
        xfer_bit(1'b0, mi);
        chk("pre_reset state data", bus.spi_state, 2'b10);
        nreset = 1'b0;
        #1;
        chk("midreset spi_state", bus.spi_state, 2'b00);
        chk("midreset miso_oe", bus.miso_oe, 1'b0);
        chk("midreset miso", bus.miso, 1'b0);
        chk("midreset rx_data", bus.rx_data, 8'h00);
        chk("midreset rx_valid", bus.rx_valid, 1'b0);
        chk("midreset tx_load", bus.tx_load, 1'b0);
        bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        nreset = 1'b1;
        l0 = n_load; a0 = n_acc; u0 = n_ur;
        repeat (20) @(posedge clk);
        #3;
        chk("post_reset no tx_load", n_load - l0, 0);
        chk("post_reset no rx_access", n_acc - a0, 0);
        chk("post_reset no underrun", n_ur - u0, 0);
        qm.delete(); qt.delete(); qm.push_back(8'h5A); qt.push_back(8'hC6);
        run_frame("after_reset", qm, qt, 8);
        chk("after_reset rx_data literal", bus.rx_data, 8'h5A);

        // Mode 2, minimum half-period, 16-byte random burst.
        set_mode(1'b1, 1'b0, 1'b0);
        qm.delete(); qt.delete();
        for (int i = 0; i < 16; i++) begin
            qm.push_back(8'($urandom_range(0, 255)));
            qt.push_back(8'($urandom_range(0, 255)));
        end
        run_frame("burst16", qm, qt, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_io.md
SPI_SLAVE_IO -- requirements
Module: spi_slave_io

Interface
REQ-001 Parameter SYNC, default 2: number of flip-flop stages synchronizing sclk, ss and mosi into clk; legal range 2..4.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 nreset  input  1  asynchronous active-low reset.
REQ-004 cpol  input  1  idle level of sclk; static while ss is low.
REQ-005 cpha  input  1  0: sample on leading edge, 1: sample on trailing edge; static while ss is low.
REQ-006 lsbfirst  input  1  1: bit 0 first on both mosi and miso.
REQ-007 sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-008 ss  input  1  active-low slave select, asynchronous to clk.
REQ-009 mosi  input  1  serial data from master.
REQ-010 miso  output  1  serial data to master.
REQ-011 miso_oe  output  1  miso output enable, high while selected.
REQ-012 tx_data  input  8  next byte to transmit, valid one clk cycle after tx_load.
REQ-013 tx_empty  input  1  no transmit byte available.
REQ-014 tx_load  output  1  one-cycle pulse requesting the next transmit byte.
REQ-015 tx_underrun  output  1  one-cycle pulse: byte requested while tx_empty high.
REQ-016 rx_data  output  8  last complete received byte.
REQ-017 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-018 rx_access  output  1  one-cycle pulse on end of frame (synchronized ss rise).
REQ-019 spi_state  output  2  current state: 00 IDLE, 01 LOAD, 10 DATA.

Function
REQ-020 sclk, ss, mosi SHALL each pass through SYNC flops; edges SHALL be detected by comparing last two synchronized sclk values.
REQ-021 Sample edge = rising sclk when cpol^cpha==0, else falling; shift edge = opposite edge.
REQ-022 IDLE->LOAD on synchronized ss falling; LOAD->DATA after exactly 2 cycles; any state->IDLE on synchronized ss high, taking priority over any same-cycle sclk edge.
REQ-023 On entry to LOAD: tx_load pulses (or tx_underrun if tx_empty); next cycle holding reg <= tx_data (0x00 on underrun) and tx shift reg <= same value.
REQ-024 Frame start: bit counter = 0; reload flag = cpha.
REQ-025 On sample edge in DATA: mosi shifted into rx shift reg (direction per lsbfirst); bit counter increments mod 8.
REQ-026 On sample edge with bit counter 7: rx_data <= assembled byte, rx_valid pulses next cycle, reload flag set, tx_load/tx_underrun pulse issued; holding reg updated one cycle later.
REQ-027 On shift edge in DATA: if reload flag set, tx shift reg <= holding reg and flag clears; else tx shift reg shifts one bit.
REQ-028 miso = tx shift reg bit 7 (bit 0 if lsbfirst) while ss_sync low; 0 otherwise; miso_oe = ~ss_sync.
REQ-029 Edges in IDLE/LOAD SHALL be ignored; master SHALL keep ss-to-first-edge and each sclk half-period >= SYNC+3 clk cycles.
REQ-030 Frame ending mid-byte: partial bits discarded, no rx_valid, rx_access still pulses.
REQ-031 rx_access pulses once per synchronized ss rising edge, including frames with zero bits.

Reset
REQ-032 nreset low: state IDLE, miso 0, miso_oe 0, tx_load 0, tx_underrun 0, rx_valid 0, rx_access 0, rx_data 0x00, counters/shift/holding regs and sync flops 0 except ss sync flops 1.
REQ-033 Reset asserted mid-frame: outputs return to reset values immediately; no pulse generated upon release.

Verification
REQ-034 Mode 0, msbfirst, master sends 0xA5, tx_data 0x3C -> rx_data 0xA5 with one rx_valid, master receives 0x3C, one rx_access.
REQ-035 Mode 3, lsbfirst, 2-byte frame mosi 0x01,0x80, tx_data 0x12,0x34 -> rx_valid twice with 0x01 then 0x80; master receives 0x12,0x34; tx_load pulses 3 times.
REQ-036 Mode 1, tx_empty high throughout -> tx_underrun each request, miso all zeros, rx still correct.
REQ-037 ss deasserted after 5 bits -> no rx_valid, rx_data unchanged, rx_access pulses once, state IDLE.
REQ-038 nreset pulsed after bit 3 -> all outputs reset; next full frame 0x5A received correctly.
REQ-039 SYNC=3, minimum legal sclk half-period -> 16-byte random burst matches in both directions.
